// File: rtl/fir_chk_pkg.sv
// Shared types and helpers for the FIR stream checker: state encoding,
// index width sizing, and the magnitude helper used by tolerance compares.
package fir_chk_pkg;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } chk_state_e;

   // Index width for a table of `depth` entries; never narrower than one bit.
   function automatic int idx_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

   function automatic logic [63:0] abs_val(input logic signed [63:0] v);
      return (v < 0) ? 64'(-v) : 64'(v);
   endfunction

endpackage

// File: rtl/fir_expected_rom.sv
// Expected-sample table: unpacks the flat parameter (element 0 in the MSBs)
// and returns the entry at idx combinationally; no latency, no backpressure.
module fir_expected_rom
   import fir_chk_pkg::*;
#(
   parameter int                     WIDTH    = 16,
   parameter int                     DEPTH    = 4,
   parameter logic [DEPTH*WIDTH-1:0] EXPECTED = {16'd4, 16'd12, 16'd1, 16'd20},
   localparam int                    IDX_W    = idx_width(DEPTH)
) (
   input  logic [IDX_W-1:0] idx,
   output logic [WIDTH-1:0] data
);

   logic [WIDTH-1:0] table_mem [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
      assign table_mem[g] = EXPECTED[(DEPTH-1-g)*WIDTH +: WIDTH];
   end

   // Non-power-of-two depths leave unused index codes; those read as zero.
   always_comb begin
      data = '0;
      if (32'(idx) < DEPTH) data = table_mem[idx];
   end

endmodule

// File: rtl/fir_stream_checker.sv
// Self-checking FIR output sink: flags/counters update 1 cycle after an accepted
// sample; never stalls the stream. Define FIR_CHK_TOLERANCE_EN for |diff|<=TOL matching.
module fir_stream_checker
   import fir_chk_pkg::*;
#(
   parameter int                     WIDTH    = 16,
   parameter int                     DEPTH    = 4,
   parameter logic [DEPTH*WIDTH-1:0] EXPECTED = {16'd4, 16'd12, 16'd1, 16'd20},
   parameter int                     LOOP     = 0,
   parameter int                     CNT_W    = 8,
   parameter int                     TOL      = 0,
   localparam int                    IDX_W    = idx_width(DEPTH)
) (
   input  logic             system1000,
   input  logic             system1000_rstn,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   input  logic             i_clear,
   output logic [WIDTH-1:0] o_expected,
   output logic [IDX_W-1:0] o_idx,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [IDX_W-1:0] o_first_err_idx,
   output logic             o_pass,
   output logic             o_done
);

   localparam logic [0:0]       RUN      = ST_RUN;
   localparam logic [0:0]       DONE     = ST_DONE;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [0:0] state;
   logic       accept;
   logic       mismatch;

   fir_expected_rom #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .EXPECTED (EXPECTED)
   ) u_rom (
      .idx  (o_idx),
      .data (o_expected)
   );

   assign accept = i_valid && (state == RUN);

`ifdef FIR_CHK_TOLERANCE_EN
   // One extra bit keeps the signed difference of two WIDTH-bit values exact.
   logic signed [WIDTH:0]  diff;
   logic signed [63:0]     diff_ext;
   always_comb begin
      diff     = $signed({i_data[WIDTH-1], i_data}) - $signed({o_expected[WIDTH-1], o_expected});
      diff_ext = 64'(diff);
      mismatch = (abs_val(diff_ext) > 64'(TOL)) || ((^i_data) === 1'bx);
   end
`else
   // Case inequality so an X/Z bit on the sample counts as a miss in simulation.
   always_comb mismatch = (i_data !== o_expected);
`endif

   always_ff @(posedge system1000 or posedge system1000_rstn) begin
      if (system1000_rstn) begin
         state           <= RUN;
         o_idx           <= '0;
         o_err_cnt       <= '0;
         o_first_err_idx <= '0;
         o_pass          <= 1'b1;
         o_done          <= 1'b0;
      end else if (i_clear) begin
         state           <= RUN;
         o_idx           <= '0;
         o_err_cnt       <= '0;
         o_first_err_idx <= '0;
         o_pass          <= 1'b1;
         o_done          <= 1'b0;
      end else begin
         // Looping builds pulse done; one-shot builds hold it until clear.
         if (LOOP != 0) o_done <= 1'b0;
         if (accept) begin
            if (mismatch) begin
               if (o_err_cnt != CNT_MAX) o_err_cnt <= o_err_cnt + 1'b1;
               if (o_err_cnt == '0)      o_first_err_idx <= o_idx;
               o_pass <= 1'b0;
            end
            if (o_idx == LAST_IDX) begin
               o_done <= 1'b1;
               if (LOOP != 0) o_idx <= '0;
               else           state <= DONE;
            end else begin
               o_idx <= o_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_stream_checker.sv
// Directed bench for fir_stream_checker: four instances (one-shot, looping,
// narrow saturating counter, TOL=1) share one stimulus bus; each step checks one.
module tb_fir_stream_checker;

   logic        system1000 = 1'b0;
   logic        system1000_rstn;
   logic [15:0] i_data;
   logic        i_valid;
   logic        i_clear;

   logic [15:0] a_exp, b_exp, c_exp, d_exp;
   logic [1:0]  a_idx, b_idx, c_idx, d_idx;
   logic [1:0]  a_fei, b_fei, c_fei, d_fei;
   logic [7:0]  a_err, b_err, d_err;
   logic [1:0]  c_err;
   logic        a_pass, b_pass, c_pass, d_pass;
   logic        a_done, b_done, c_done, d_done;

   int passed = 0;
   int total  = 0;
   int done_cnt;
   logic [15:0] tbl [4] = '{16'd4, 16'd12, 16'd1, 16'd20};

   always #5 system1000 = ~system1000;

   fir_stream_checker u_a (
      .system1000(system1000), .system1000_rstn(system1000_rstn),
      .i_data(i_data), .i_valid(i_valid), .i_clear(i_clear),
      .o_expected(a_exp), .o_idx(a_idx), .o_err_cnt(a_err),
      .o_first_err_idx(a_fei), .o_pass(a_pass), .o_done(a_done));

   fir_stream_checker #(.LOOP(1)) u_b (
      .system1000(system1000), .system1000_rstn(system1000_rstn),
      .i_data(i_data), .i_valid(i_valid), .i_clear(i_clear),
      .o_expected(b_exp), .o_idx(b_idx), .o_err_cnt(b_err),
      .o_first_err_idx(b_fei), .o_pass(b_pass), .o_done(b_done));

   fir_stream_checker #(.LOOP(1), .CNT_W(2)) u_c (
      .system1000(system1000), .system1000_rstn(system1000_rstn),
      .i_data(i_data), .i_valid(i_valid), .i_clear(i_clear),
      .o_expected(c_exp), .o_idx(c_idx), .o_err_cnt(c_err),
      .o_first_err_idx(c_fei), .o_pass(c_pass), .o_done(c_done));

   fir_stream_checker #(.TOL(1)) u_d (
      .system1000(system1000), .system1000_rstn(system1000_rstn),
      .i_data(i_data), .i_valid(i_valid), .i_clear(i_clear),
      .o_expected(d_exp), .o_idx(d_idx), .o_err_cnt(d_err),
      .o_first_err_idx(d_fei), .o_pass(d_pass), .o_done(d_done));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic send(input logic [15:0] d, input logic v);
      @(negedge system1000);
      i_data  = d;
      i_valid = v;
   endtask

   task automatic idle();
      @(negedge system1000);
      i_valid = 1'b0;
      i_data  = 16'h7777;
   endtask

   task automatic do_clear();
      @(negedge system1000);
      i_clear = 1'b1;
      i_valid = 1'b0;
      @(negedge system1000);
      i_clear = 1'b0;
   endtask

   initial begin
      system1000_rstn = 1'b1;
      i_data  = '0;
      i_valid = 1'b0;
      i_clear = 1'b0;
      repeat (3) @(negedge system1000);
      chk("rst_idx",  32'(a_idx),  0);
      chk("rst_err",  32'(a_err),  0);
      chk("rst_fei",  32'(a_fei),  0);
      chk("rst_pass", 32'(a_pass), 1);
      chk("rst_done", 32'(a_done), 0);
      chk("rst_exp",  32'(a_exp),  4);
      system1000_rstn = 1'b0;

      // Clean pass, then extra samples while DONE must be ignored.
      for (int i = 0; i < 4; i++) send(tbl[i], 1'b1);
      idle();
      chk("p1_done", 32'(a_done), 1);
      chk("p1_pass", 32'(a_pass), 1);
      chk("p1_err",  32'(a_err),  0);
      chk("p1_idx",  32'(a_idx),  3);
      chk("p1_exp",  32'(a_exp),  20);
      send(16'd99, 1'b1);
      idle();
      chk("done_hold_err",  32'(a_err),  0);
      chk("done_hold_pass", 32'(a_pass), 1);
      chk("done_hold_idx",  32'(a_idx),  3);

      // Two mismatches at indices 1 and 3.
      do_clear();
      chk("clr_done", 32'(a_done), 0);
      send(16'd4, 1'b1); send(16'd13, 1'b1); send(16'd1, 1'b1); send(16'd21, 1'b1);
      idle();
      chk("mm_err",  32'(a_err),  2);
      chk("mm_fei",  32'(a_fei),  1);
      chk("mm_pass", 32'(a_pass), 0);
      chk("mm_done", 32'(a_done), 1);

      // Valid on cycles 0,3,4,9 only.
      do_clear();
      send(16'd4, 1'b1); idle(); idle();
      chk("gap_idx_hold", 32'(a_idx), 1);
      send(16'd12, 1'b1); send(16'd1, 1'b1);
      repeat (4) idle();
      chk("gap_idx_mid",  32'(a_idx),  3);
      chk("gap_done_mid", 32'(a_done), 0);
      send(16'd20, 1'b1);
      idle();
      chk("gap_idx",  32'(a_idx),  3);
      chk("gap_pass", 32'(a_pass), 1);
      chk("gap_done", 32'(a_done), 1);

      // Looping instance: ten samples, done pulses after samples 4 and 8.
      do_clear();
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge system1000);
         done_cnt += int'(b_done);
         i_data  = tbl[i % 4];
         i_valid = 1'b1;
      end
      idle();
      done_cnt += int'(b_done);
      idle();
      done_cnt += int'(b_done);
      chk("loop_pulses", 32'(done_cnt), 2);
      chk("loop_idx",    32'(b_idx),    2);
      chk("loop_pass",   32'(b_pass),   1);
      chk("loop_done",   32'(b_done),   0);

      // Narrow counter saturates; clear beats a same-cycle valid.
      do_clear();
      for (int i = 0; i < 6; i++) send(16'hFFF9, 1'b1);
      idle();
      chk("sat_err",  32'(c_err),  3);
      chk("sat_fei",  32'(c_fei),  0);
      chk("sat_pass", 32'(c_pass), 0);
      chk("sat_idx",  32'(c_idx),  2);
      @(negedge system1000);
      i_clear = 1'b1;
      i_valid = 1'b1;
      i_data  = 16'd4;
      @(negedge system1000);
      i_clear = 1'b0;
      i_valid = 1'b0;
      chk("clrv_idx",  32'(c_idx),  0);
      chk("clrv_err",  32'(c_err),  0);
      chk("clrv_fei",  32'(c_fei),  0);
      chk("clrv_pass", 32'(c_pass), 1);
      chk("clrv_done", 32'(c_done), 0);

      // Tolerance instance: 5,11,1,22 against 4,12,1,20.
      do_clear();
      send(16'd5, 1'b1); send(16'd11, 1'b1); send(16'd1, 1'b1); send(16'd22, 1'b1);
      idle();
`ifdef FIR_CHK_TOLERANCE_EN
      chk("tol_err", 32'(d_err), 1);
      chk("tol_fei", 32'(d_fei), 3);
`else
      chk("tol_err", 32'(d_err), 3);
      chk("tol_fei", 32'(d_fei), 0);
`endif
      chk("tol_pass", 32'(d_pass), 0);
      chk("tol_done", 32'(d_done), 1);

      // Asynchronous reset in the middle of a pass.
      do_clear();
      send(16'd4, 1'b1); send(16'd99, 1'b1);
      idle();
      chk("mid_idx", 32'(d_idx), 2);
      chk("mid_err", 32'(d_err), 1);
      @(negedge system1000);
      system1000_rstn = 1'b1;
      #1;
      chk("arst_idx",  32'(d_idx),  0);
      chk("arst_err",  32'(d_err),  0);
      chk("arst_fei",  32'(d_fei),  0);
      chk("arst_pass", 32'(d_pass), 1);
      chk("arst_done", 32'(d_done), 0);
      @(negedge system1000);
      system1000_rstn = 1'b0;
      idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
